// File: rtl/fma_seq.sv
// fma_seq: handshaked multi-cycle a*b +/- c sequencer driving one shared fmul and one shared fadd.
// Both arithmetic blocks are IEEE-754 single, round-to-nearest-even, subnormal-aware, canonical NaN.
module fma_seq #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [31:0]      in_c,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Round value m * 2^e (e is two's complement) to single; lsb of m may hold a sticky bit.
  function automatic logic [31:0] round_pack(input logic s, input logic [11:0] e, input logic [63:0] m);
    logic [5:0]  lz;
    logic [5:0]  sh;
    logic [63:0] mn;
    logic [63:0] mn2;
    logic [63:0] mask;
    logic [11:0] be;
    logic [11:0] ebase;
    logic [11:0] tmp;
    logic [23:0] kept;
    logic        rb;
    logic        st;
    logic [24:0] rnd;
    logic [35:0] acc;
    lz = 6'd0;
    for (int i = 0; i < 64; i++)
      if (m[i]) lz = 6'(63 - i);
    mn = m << lz;
    be = e + 12'd190 - {6'd0, lz};
    if (!be[11] && be != 12'd0) begin
      sh    = 6'd0;
      ebase = be - 12'd1;
    end else begin
      tmp   = 12'd1 - be;
      sh    = (tmp > 12'd63) ? 6'd63 : tmp[5:0];
      ebase = 12'd0;
    end
    mask = ~({64{1'b1}} << sh);
    mn2  = mn >> sh;
    kept = mn2[63:40];
    rb   = mn2[39];
    st   = (|mn2[38:0]) | (|(mn & mask));
    rnd  = {1'b0, kept} + {24'd0, rb & (st | kept[0])};
    // the hidden bit of rnd carries into the exponent field, which also covers subnormal->normal
    acc  = {1'b0, ebase, 23'd0} + {11'd0, rnd};
    if (acc[35:23] >= 13'd255) return {s, 8'hFF, 23'd0};
    return {s, acc[30:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [23:0] ma, mb;
    logic [47:0] p;
    logic [11:0] e;
    s      = a[31] ^ b[31];
    a_nan  = (&a[30:23]) & (|a[22:0]);
    b_nan  = (&b[30:23]) & (|b[22:0]);
    a_inf  = (&a[30:23]) & ~(|a[22:0]);
    b_inf  = (&b[30:23]) & ~(|b[22:0]);
    a_zero = ~(|a[30:0]);
    b_zero = ~(|b[30:0]);
    ma     = {|a[30:23], a[22:0]};
    mb     = {|b[30:23], b[22:0]};
    p      = 48'(ma) * 48'(mb);
    e      = {4'd0, a[30:23]} + {11'd0, ~(|a[30:23])}
           + {4'd0, b[30:23]} + {11'd0, ~(|b[30:23])} - 12'd300;
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) return QNAN;
    if (a_inf | b_inf) return {s, 8'hFF, 23'd0};
    if (a_zero | b_zero) return {s, 31'd0};
    return round_pack(s, e, {16'd0, p});
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0]  ex, ey, d;
    logic [49:0] mx, my, my_sh, mask;
    logic [50:0] sum;
    logic        a_nan, b_nan, a_inf, b_inf;
    a_nan = (&a[30:23]) & (|a[22:0]);
    b_nan = (&b[30:23]) & (|b[22:0]);
    a_inf = (&a[30:23]) & ~(|a[22:0]);
    b_inf = (&b[30:23]) & ~(|b[22:0]);
    if (a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31]))) return QNAN;
    if (a_inf) return a;
    if (b_inf) return b;
    // x holds the larger magnitude so the difference below is never negative
    if (b[30:0] > a[30:0]) begin
      x = b; y = a;
    end else begin
      x = a; y = b;
    end
    ex    = (|x[30:23]) ? x[30:23] : 8'd1;
    ey    = (|y[30:23]) ? y[30:23] : 8'd1;
    d     = ex - ey;
    mx    = {|x[30:23], x[22:0], 26'd0};
    my    = {|y[30:23], y[22:0], 26'd0};
    mask  = ~({50{1'b1}} << d);
    my_sh = (my >> d) | {49'd0, |(my & mask)};
    if (x[31] == y[31]) sum = {1'b0, mx} + {1'b0, my_sh};
    else                sum = {1'b0, mx} - {1'b0, my_sh};
    if (sum == 51'd0) return {x[31] & y[31], 31'd0};
    return round_pack(x[31], {4'd0, ex} - 12'd176, {13'd0, sum});
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ADD, S_DONE} state_t;

  state_t           r_state;
  logic [31:0]      r_a, r_b, r_c, r_prod, r_res;
  logic [1:0]       r_op;
  logic [TAG_W-1:0] r_tag, r_out_tag;
  logic [31:0]      w_mul_a, w_add_c, w_prod, w_sum;

  // negation is a pure sign flip so NaN/inf/zero encodings keep their payload
  assign w_mul_a = {r_a[31] ^ r_op[1], r_a[30:0]};
  assign w_add_c = {r_c[31] ^ r_op[0], r_c[30:0]};
  assign w_prod  = fp_mul(w_mul_a, r_b);
  assign w_sum   = fp_add(r_prod, w_add_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_c       <= 32'd0;
      r_op      <= 2'd0;
      r_tag     <= '0;
      r_prod    <= 32'd0;
      r_res     <= 32'd0;
      r_out_tag <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a     <= in_a;
          r_b     <= in_b;
          r_c     <= in_c;
          r_op    <= in_op;
          r_tag   <= in_tag;
          r_state <= S_MUL;
        end
        S_MUL: begin
          r_prod  <= w_prod;
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_res     <= w_sum;
          r_out_tag <= r_tag;
          r_state   <= S_DONE;
        end
        default: if (out_ready) r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_res   = r_res;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_fma_seq.sv
// Self-checking bench for fma_seq: directed steps plus random operations against a real-arithmetic model.
module tb_fma_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'd0, in_b = 32'd0, in_c = 32'd0;
  logic [1:0]  in_op = 2'd0;
  logic [3:0]  in_tag = 4'd0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_res;
  logic [3:0]  out_tag;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] specials [8] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                 32'h7FC0_0000, 32'h0000_0001, 32'h7F7F_FFFF, 32'h0080_0000};

  fma_seq #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_op(in_op), .in_tag(in_tag),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r * 0.5;
    return r;
  endfunction

  // exact single -> double
  function automatic real f2r(input logic [31:0] f);
    real mag;
    if (&f[30:23]) begin
      if (|f[22:0]) return $bitstoreal(64'h7FF8_0000_0000_0000);
      mag = $bitstoreal(64'h7FF0_0000_0000_0000);
    end else if (f[30:23] == 8'd0)
      mag = real'(f[22:0]) * pow2(-149);
    else
      mag = real'({1'b1, f[22:0]}) * pow2(int'(f[30:23]) - 150);
    if (f[31]) mag = $bitstoreal($realtobits(mag) | 64'h8000_0000_0000_0000);
    return mag;
  endfunction

  // double -> single, round to nearest even, any NaN becomes the canonical quiet NaN
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d, m, kept;
    logic        s, rb, st;
    int          e, sh;
    d = $realtobits(r);
    s = d[63];
    if (d[62:52] == 11'h7FF) return (d[51:0] != 52'd0) ? 32'h7FC0_0000 : {s, 8'hFF, 23'd0};
    if (d[62:52] == 11'd0) return {s, 31'd0};
    e  = int'(d[62:52]) - 1023;
    m  = {11'd0, 1'b1, d[51:0]};
    sh = (e >= -126) ? 29 : 29 + (-126 - e);
    if (sh > 62) return {s, 31'd0};
    kept = m >> sh;
    rb   = m[sh-1];
    st   = (m & ((64'd1 << (sh - 1)) - 64'd1)) != 64'd0;
    kept = kept + {63'd0, rb & (st | kept[0])};
    if (e >= -126) kept = kept + (64'(e + 126) << 23);
    if (kept >= 64'h7F80_0000) return {s, 8'hFF, 23'd0};
    return {s, kept[30:0]};
  endfunction

  // product rounded to single, then sum rounded to single
  function automatic logic [31:0] ref_fma(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [1:0] op);
    logic [31:0] an, cn, p;
    an = {a[31] ^ op[1], a[30:0]};
    cn = {c[31] ^ op[0], c[30:0]};
    p  = r2f(f2r(an) * f2r(b));
    return r2f(f2r(p) + f2r(cn));
  endfunction

  function automatic logic [31:0] rnd_f(input logic [31:0] near);
    logic [31:0] v;
    int          k;
    k = $urandom_range(0, 9);
    v = $urandom;
    if (k < 3) return v;
    if (k < 7) v[30:23] = 8'($urandom_range(118, 136));
    else if (k == 7) v[30:23] = near[30:23];
    else if (k == 8) v[30:23] = 8'($urandom_range(0, 3));
    else v = specials[$urandom_range(0, 7)] ^ {$urandom_range(0, 1) == 1, 31'd0};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // called just after a negedge with the unit idle; returns just after a negedge, unit idle
  task automatic do_op(input string lbl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [1:0] op, input logic [3:0] tag,
                       input logic [31:0] exp, input int stall);
    int w;
    chk({lbl, ".rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_op = op; in_tag = tag;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_c = $urandom;
    in_op = 2'($urandom); in_tag = 4'($urandom);
    w = 1;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({lbl, ".lat"}, 32'(w), 32'd3);
    chk({lbl, ".res"}, out_res, exp);
    chk({lbl, ".tag"}, 32'(out_tag), 32'(tag));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk({lbl, ".hold_flags"}, {30'd0, out_valid, in_ready}, 32'd2);
      chk({lbl, ".hold_res"}, out_res, exp);
    end
    in_valid = (stall != 0);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({lbl, ".release"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a, b, c;
    logic [1:0]  op;
    logic [3:0]  tag;

    // reset with random inputs
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); in_a = $urandom; in_b = $urandom; in_c = $urandom;
      in_op = 2'($urandom); in_tag = 4'($urandom); abort = 1'($urandom); out_ready = 1'($urandom);
      @(negedge clk);
    end
    chk("reset.flags", {30'd0, out_valid, in_ready}, 32'd1);
    chk("reset.res", out_res, 32'd0);
    chk("reset.tag", 32'(out_tag), 32'd0);
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle.flags", {30'd0, out_valid, in_ready}, 32'd1);

    // the four sign variants of 2*3 +/- 1
    do_op("op00", 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'b00, 4'd1, 32'h40E0_0000, 0);
    do_op("op01", 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'b01, 4'd2, 32'h40A0_0000, 0);
    do_op("op10", 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'b10, 4'd3, 32'hC0A0_0000, 0);
    do_op("op11", 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'b11, 4'd4, 32'hC0E0_0000, 0);

    // backpressure for 10 cycles
    do_op("bp", 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'b00, 4'd7, 32'h40E0_0000, 10);

    // abort in the ADD cycle
    in_valid = 1'b1; in_a = 32'h4000_0000; in_b = 32'h4040_0000; in_c = 32'h3F80_0000;
    in_op = 2'b00; in_tag = 4'd5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_add.flags", {30'd0, out_valid, in_ready}, 32'd1);
    chk("abort_add.tag", 32'(out_tag), 32'd7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_add.quiet", 32'(out_valid), 32'd0);
    end
    do_op("after_abort", 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'b01, 4'd6, 32'h40A0_0000, 0);

    // abort in IDLE suppresses capture
    in_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_idle.rdy", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("abort_idle.quiet", 32'(out_valid), 32'd0);

    // abort while holding a result
    in_valid = 1'b1; out_ready = 1'b0; in_tag = 4'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_done.pre", 32'(out_valid), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b1;
    chk("abort_done.flags", {30'd0, out_valid, in_ready}, 32'd1);

    // special values
    do_op("inf_minus_inf", 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 2'b01, 4'd10, 32'h7FC0_0000, 0);
    do_op("neg_zero", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'b11, 4'd11, 32'h8000_0000, 0);

    // asynchronous reset during MUL
    in_valid = 1'b1; in_a = 32'h4000_0000; in_b = 32'h4040_0000; in_c = 32'h3F80_0000;
    in_op = 2'b00; in_tag = 4'd12;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("async_rst.flags", {30'd0, out_valid, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("async_rst.quiet", {27'd0, out_valid, out_tag}, 32'd0);
    end

    // random operations against the reference model
    for (int i = 0; i < 150; i++) begin
      a   = rnd_f(32'h3F80_0000);
      b   = rnd_f(a);
      c   = rnd_f(r2f(f2r(a) * f2r(b)));
      op  = 2'($urandom);
      tag = 4'($urandom);
      do_op("rand", a, b, c, op, tag, ref_fma(a, b, c, op),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
